// File: rtl/instruction_fetch_if.sv
// Fetch-stage handshake bundle: instruction memory request/grant/response,
// execute redirect, and the valid/ready instruction stream to the decoder.
//   master : the fetch unit (drives imemReq/imemAddr, instr*, fetchError)
//   slave  : the surroundings (memory, execute, decoder)
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

interface instruction_fetch_if;
  logic                          imemReq;
  logic [`DATA_WIDTH-1:0]        imemAddr;
  logic                          imemGnt;
  logic                          imemRespValid;
  logic [`INSTRUCTION_WIDTH-1:0] imemRdata;
  logic                          redirectValid;
  logic [`DATA_WIDTH-1:0]        redirectTarget;
  logic                          instrValid;
  logic                          instrReady;
  logic [`INSTRUCTION_WIDTH-1:0] instrOut;
  logic [`DATA_WIDTH-1:0]        pcOut;
  logic                          fetchError;

  modport master (
    output imemReq, imemAddr, instrValid, instrOut, pcOut, fetchError,
    input  imemGnt, imemRespValid, imemRdata, redirectValid, redirectTarget, instrReady
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instrOut, pcOut, fetchError,
    output imemGnt, imemRespValid, imemRdata, redirectValid, redirectTarget, instrReady
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory, buffers responses with their PCs in a 2-entry FIFO and
// hands them to the decoder. Redirects from execute reload the PC, flush the
// FIFO and discard any in-flight response.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - synchronous active-low reset
//   bus      - instruction_fetch_if.master (memory, redirect, decoder side)
// Optional feature macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target
// raises a sticky fetchError and halts fetching; when undefined the target's
// low two bits are cleared and fetchError is tied low.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module instruction_fetch #(
  parameter logic [`DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned            FIFO_DEPTH   = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  instruction_fetch_if.master bus
);
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned IW = `INSTRUCTION_WIDTH;
  localparam int unsigned CW = 2;

  // FETCH: idle, WAIT: response pending, DRAIN: pending response is stale.
  // The halted condition is carried by fetch_error on top of these.
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_t;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [DW-1:0] pc;
  } entry_t;

  state_t        state;
  logic [DW-1:0] pc;
  logic [DW-1:0] req_pc;
  logic [CW-1:0] count;
  entry_t        head;
  entry_t        tail;
  logic          fetch_error;

  logic          outstanding;
  logic          grant;
  logic          pop;
  logic          push;
  logic [DW-1:0] target;
  entry_t        new_entry;

  // Redirect target handling and the sticky error flag
`ifdef FETCH_ALIGN_CHECK_EN
  assign target = bus.redirectTarget;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_error <= 1'b0;
    end else if (bus.redirectValid && (bus.redirectTarget[1:0] != 2'b00)) begin
      fetch_error <= 1'b1;
    end
  end
`else
  assign target      = bus.redirectTarget & ~DW'(3);
  assign fetch_error = 1'b0;
`endif

  assign outstanding = (state != S_FETCH);
  assign grant       = bus.imemReq && bus.imemGnt;
  assign pop         = bus.instrValid && bus.instrReady;
  // Only a live (non-drained) response outside a redirect cycle is kept
  assign push        = (state == S_WAIT) && bus.imemRespValid && !bus.redirectValid;
  assign new_entry   = '{instr: bus.imemRdata, pc: req_pc};

  // Request is combinational so a grant can land the cycle the FIFO frees up
  assign bus.imemReq    = reset_n && !outstanding && (count < CW'(FIFO_DEPTH))
                          && !bus.redirectValid && !fetch_error;
  assign bus.imemAddr   = pc;
  assign bus.instrValid = (count != '0);
  assign bus.instrOut   = head.instr;
  assign bus.pcOut      = head.pc;
  assign bus.fetchError = fetch_error;

  // Control state, PC and output FIFO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_FETCH;
      pc     <= RESET_VECTOR;
      req_pc <= '0;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
    end else begin
      if (bus.redirectValid) begin
        pc <= target;
        // A response that never arrives in this cycle must be dropped later
        state <= (outstanding && !bus.imemRespValid) ? S_DRAIN : S_FETCH;
      end else begin
        unique case (state)
          S_FETCH: begin
            if (grant) begin
              state  <= S_WAIT;
              req_pc <= pc;
              pc     <= pc + DW'(4);
            end
          end
          S_WAIT, S_DRAIN: begin
            if (bus.imemRespValid) state <= S_FETCH;
          end
          default: state <= S_FETCH;
        endcase
      end

      // Head is entry 0; a push at count 2 cannot occur
      if (bus.redirectValid) begin
        count <= '0;
      end else if (push && pop) begin
        if (count == CW'(1)) begin
          head <= new_entry;
        end else begin
          head <= tail;
          tail <= new_entry;
        end
      end else if (pop) begin
        head  <= tail;
        count <= count - CW'(1);
      end else if (push) begin
        if (count == '0) head <= new_entry;
        else             tail <= new_entry;
        count <= count + CW'(1);
      end
    end
  end
endmodule
